// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- single-issue ALU with a valid/ready handshake on both sides and
// a registered result slot.
//
// Non-multiply operations are evaluated combinationally from the offered
// operands. Their result and flags are captured at the acceptance edge, so the
// result appears one cycle later. The multiply is an iterative shift-add unit
// that retires one multiplier bit per cycle.
//
// Configuration macro: ALU_PIPE_MUL_EN
//   defined   -> opcode 10 (MUL) and the MUL_BUSY state are built.
//   undefined -> no multiplier logic; opcode 10 is treated as an undefined op.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation offered
//   in_ready   operation accepted at the edge where in_valid && in_ready
//   exe_cmd    opcode: 1 MOV, 9 MVN, 2 ADD, 3 ADC, 4 SUB, 5 SBC, 6 AND,
//              7 ORR, 8 EOR, 10 MUL
//   s_bit      write this op's flags into the status register
//   val1/val2  operands (WIDTH bits)
//   out_valid  alu_res holds a result
//   out_ready  result consumed at the edge where out_valid && out_ready
//   alu_res    registered result
//   status     flags register {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       status
);

  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SBC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_ORR = 4'd7;
  localparam logic [3:0] OP_EOR = 4'd8;
  localparam logic [3:0] OP_MVN = 4'd9;

  // Result slot and flags register
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_res_q, alu_res_d;
  logic [3:0]       status_q, status_d;

  // Combinational ALU outputs
  logic [WIDTH-1:0] alu_val;
  logic             op_defined;
  logic             op_arith;
  logic             sub_op;
  logic             carry_in;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             flag_c;
  logic             flag_v;

  logic accept;
  logic slot_free;
  logic idle;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam int         CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_s_q, mul_s_d;

  assign idle = (state_q == ST_IDLE);
`else
  assign idle = 1'b1;
`endif

  assign in_ready  = idle && (!out_valid_q || out_ready) && !rst;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;

  // ALU datapath. Subtraction runs through the same adder as val1 + ~val2 +
  // carry_in, which makes the adder carry-out equal to "no borrow" directly.
  always_comb begin
    op_defined = 1'b1;
    op_arith   = 1'b0;
    sub_op     = 1'b0;
    carry_in   = 1'b0;
    case (exe_cmd)
      OP_ADD: op_arith = 1'b1;
      OP_ADC: begin
        op_arith = 1'b1;
        carry_in = status_q[1];
      end
      OP_SUB: begin
        op_arith = 1'b1;
        sub_op   = 1'b1;
        carry_in = 1'b1;
      end
      OP_SBC: begin
        op_arith = 1'b1;
        sub_op   = 1'b1;
        carry_in = status_q[1];
      end
      default: ;
    endcase

    b_op   = sub_op ? ~val2 : val2;
    sum    = {1'b0, val1} + {1'b0, b_op} + {{WIDTH{1'b0}}, carry_in};
    flag_c = sum[WIDTH];
    // Overflow: both adder inputs share a sign that the sum does not.
    flag_v = (val1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != val1[WIDTH-1]);

    case (exe_cmd)
      OP_MOV: alu_val = val2;
      OP_MVN: alu_val = ~val2;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_val = sum[WIDTH-1:0];
      OP_AND: alu_val = val1 & val2;
      OP_ORR: alu_val = val1 | val2;
      OP_EOR: alu_val = val1 ^ val2;
      default: begin
        alu_val    = '0;
        op_defined = 1'b0;
      end
    endcase
  end

  // Next-state logic for the result slot, flags and multiplier FSM
  always_comb begin
    out_valid_d = out_valid_q;
    alu_res_d   = alu_res_q;
    status_d    = status_q;
`ifdef ALU_PIPE_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_s_d  = mul_s_q;
`endif

    // Consumption clears the slot; a load later in this block overrides it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
`ifdef ALU_PIPE_MUL_EN
      if (exe_cmd == OP_MUL) begin
        state_d  = ST_MUL_BUSY;
        mcand_d  = val1;
        mplier_d = val2;
        acc_d    = '0;
        cnt_d    = '0;
        mul_s_d  = s_bit;
      end else
`endif
      begin
        alu_res_d   = alu_val;
        out_valid_d = 1'b1;
        if (s_bit && op_defined) begin
          status_d = {alu_val[WIDTH-1], (alu_val == '0),
                      op_arith ? flag_c : status_q[1],
                      op_arith ? flag_v : status_q[0]};
        end
      end
    end

`ifdef ALU_PIPE_MUL_EN
    if (state_q == ST_MUL_BUSY) begin
      if (cnt_q != CNT_DONE) begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end else if (slot_free) begin
        // Product complete; it stays frozen in acc_q until the slot frees.
        alu_res_d   = acc_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
        if (mul_s_q) begin
          status_d = {acc_q[WIDTH-1], (acc_q == '0), status_q[1:0]};
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_res_q   <= '0;
      status_q    <= 4'b0000;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_s_q     <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      alu_res_q   <= alu_res_d;
      status_q    <= status_d;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      mul_s_q     <= mul_s_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign alu_res   = alu_res_q;
  assign status    = status_q;

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe at WIDTH = 32.
// A cycle-level reference model computes the expected result slot, flags and
// in_ready from plain 64-bit arithmetic; a compare process checks the DUT
// against it every cycle after the first reset. Directed vectors add literal
// expectations that pin the model. Works with or without ALU_PIPE_MUL_EN.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    exe_cmd;
  logic          s_bit;
  logic [W-1:0]  val1;
  logic [W-1:0]  val2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_res;
  logic [3:0]    status;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exe_cmd   (exe_cmd),
    .s_bit     (s_bit),
    .val1      (val1),
    .val2      (val2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_res   (alu_res),
    .status    (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Evaluates one non-multiply op from the arithmetic definitions.
  function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, input bit s,
                                  input logic [3:0] st,
                                  output logic [31:0] r, output logic [3:0] st_n);
    bit defd = 1'b1;
    bit c = st[1];
    bit v = st[0];
    bit bor;
    int ci;
    longint unsigned us;
    longint ss;
    r = '0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd2, 4'd3: begin
        ci = (cmd == 4'd3) ? int'(st[1]) : 0;
        us = 64'(a) + 64'(b) + 64'(ci);
        ss = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        r  = us[31:0];
        c  = (us > 64'hFFFF_FFFF);
        v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        bor = (cmd == 4'd5) ? !st[1] : 1'b0;
        r   = a - b - 32'(bor);
        c   = (64'(a) >= 64'(b) + 64'(bor));
        ss  = longint'($signed(a)) - longint'($signed(b)) - longint'(bor);
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: defd = 1'b0;
    endcase
    if (s && defd) st_n = {r[31], (r == 32'd0), c, v};
    else           st_n = st;
  endfunction

  logic        m_ov;
  logic [31:0] m_res;
  logic [3:0]  m_st;
  bit          m_busy;
  int          m_cnt;
  logic [31:0] m_prod;
  bit          m_ps;
  bit          m_init = 1'b0;

  function automatic bit m_rdy();
    return !m_busy && (!m_ov || out_ready) && !rst;
  endfunction

  always @(posedge clk) begin
    bit          acc;
    bit          free;
    logic [31:0] r;
    logic [3:0]  sn;
    if (rst) begin
      m_init = 1'b1;
      m_ov   = 1'b0;
      m_res  = '0;
      m_st   = 4'b0000;
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_init) begin
      acc  = in_valid && m_rdy();
      free = !m_ov || out_ready;
      if (m_ov && out_ready) m_ov = 1'b0;
      if (acc) begin
        if (MUL_EN && exe_cmd == 4'd10) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_prod = val1 * val2;
          m_ps   = s_bit;
        end else begin
          ref_alu(exe_cmd, val1, val2, s_bit, m_st, r, sn);
          m_res = r;
          m_st  = sn;
          m_ov  = 1'b1;
        end
      end else if (m_busy) begin
        // Product becomes visible WIDTH+1 edges after the accept edge.
        m_cnt++;
        if (m_cnt >= W + 1 && free) begin
          m_res  = m_prod;
          m_ov   = 1'b1;
          m_busy = 1'b0;
          if (m_ps) m_st = {m_prod[31], (m_prod == 32'd0), m_st[1:0]};
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (m_init) begin
      chk("cmp_out_valid", 64'(out_valid), 64'(m_ov));
      chk("cmp_alu_res",   64'(alu_res),   64'(m_res));
      chk("cmp_status",    64'(status),    64'(m_st));
      chk("cmp_in_ready",  64'(in_ready),  64'(m_rdy()));
    end
  end

  // ---------------- stimulus ----------------
  // Offer one op; returns at the falling edge after the accept edge.
  task automatic issue(input logic [3:0] cmd, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    exe_cmd  = cmd;
    s_bit    = s;
    val1     = a;
    val2     = b;
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 100 && !in_ready; k++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    $display("op cmd=%0d s=%0d a=%h b=%h", cmd, s, a, b);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] r, input logic [3:0] st);
    chk({nm, "_valid"},  64'(out_valid), 64'd1);
    chk({nm, "_res"},    64'(alu_res),   64'(r));
    chk({nm, "_status"}, 64'(status),    64'(st));
  endtask

  initial begin
    int  k;
    bit  stale;
    rst       = 1'b1;
    in_valid  = 1'b0;
    exe_cmd   = '0;
    s_bit     = 1'b0;
    val1      = '0;
    val2      = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_res",   64'(alu_res),   64'd0);
    chk("rst_status",    64'(status),    64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready",  64'(in_ready),  64'd1);

    issue(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
    expect_out("add_ovf", 32'h8000_0000, 4'b1001);
    issue(4'd4, 1'b1, 32'd3, 32'd5);
    expect_out("sub_neg", 32'hFFFF_FFFE, 4'b1000);
    issue(4'd5, 1'b1, 32'd10, 32'd3);
    expect_out("sbc_borrow_in", 32'h0000_0006, 4'b0010);
    issue(4'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    expect_out("add_nos", 32'h0000_0000, 4'b0010);
    issue(4'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
    expect_out("adc_carry", 32'h0000_0000, 4'b0110);
    issue(4'd9, 1'b1, 32'h0, 32'h0000_FFFF);
    expect_out("mvn", 32'hFFFF_0000, 4'b1010);
    issue(4'd6, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    expect_out("and", 32'h0000_0000, 4'b0110);
    issue(4'd7, 1'b1, 32'hF0F0_0000, 32'h0000_000F);
    expect_out("orr", 32'hF0F0_000F, 4'b1010);
    issue(4'd8, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    expect_out("eor", 32'h0000_0000, 4'b0110);
    issue(4'd1, 1'b1, 32'd5, 32'h1234_5678);
    expect_out("mov", 32'h1234_5678, 4'b0010);
    issue(4'd4, 1'b1, 32'h8000_0000, 32'h0000_0001);
    expect_out("sub_ovf", 32'h7FFF_FFFF, 4'b0011);
    issue(4'd0, 1'b1, 32'd1, 32'd2);
    expect_out("undef0", 32'h0, 4'b0011);
    issue(4'd15, 1'b1, 32'd1, 32'd2);
    expect_out("undef15", 32'h0, 4'b0011);

    // Backpressure: drain, then hold a result for 5 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'd2, 1'b0, 32'd5, 32'd6);
    for (int i = 0; i < 5; i++) begin
      expect_out("hold", 32'h0000_000B, 4'b0011);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(4'd4, 1'b1, 32'd7, 32'd7);
    expect_out("replace", 32'h0, 4'b0110);

    // Multiply (or undefined opcode 10 without the multiplier).
    issue(4'd10, 1'b1, 32'h0001_0000, 32'h0001_0001);
    if (MUL_EN) begin
      chk("mul_ov_low", 64'(out_valid), 64'd0);
      k = 0;
      while (!out_valid && k < 100) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("mul_latency", 64'(k), 64'd33);
      expect_out("mul", 32'h0001_0000, 4'b0010);
    end else begin
      expect_out("mul_undef", 32'h0, 4'b0110);
    end

    // Reset pulsed into a multiply: nothing may be delivered afterwards.
    @(negedge clk);
    issue(4'd10, 1'b1, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_status",    64'(status),    64'd0);
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    stale = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("abort_no_stale", 64'(stale), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operation offered.
REQ-005 in_ready  output  1  operation accepted on clk edge when in_valid && in_ready.
REQ-006 exe_cmd  input  4  opcode: 1 MOV, 9 MVN, 2 ADD, 3 ADC, 4 SUB, 5 SBC, 6 AND, 7 ORR, 8 EOR, 10 MUL.
REQ-007 s_bit  input  1  update flags register with this op's flags.
REQ-008 val1, val2  input  WIDTH  operands.
REQ-009 out_valid  output  1  alu_res holds a result.
REQ-010 out_ready  input  1  result consumed on clk edge when out_valid && out_ready.
REQ-011 alu_res  output  WIDTH  registered result.
REQ-012 status  output  4  flags register {N,Z,C,V} at bits [3:0] = [3]N [2]Z [1]C [0]V.

Function
REQ-013 FSM states IDLE and MUL_BUSY; IDLE -> MUL_BUSY on acceptance of MUL; MUL_BUSY -> IDLE on MUL completion.
REQ-014 in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst.
REQ-015 Non-MUL ops are computed at the acceptance edge; alu_res, out_valid=1 and flags (if s_bit) are registered at that same edge, so latency is 1 cycle.
REQ-016 ADC computes val1+val2+C, SBC computes val1-val2-(1-C), C taken from the status register as of the acceptance edge; back-to-back ops see the previous op's flag update with no hazard.
REQ-017 ADD/ADC: C = carry out of bit WIDTH-1; SUB/SBC: C = 1 when no borrow (ARM convention).
REQ-018 V = signed overflow for ADD/ADC/SUB/SBC; V and C unchanged for MOV, MVN, AND, ORR, EOR, MUL.
REQ-019 N = alu_res[WIDTH-1], Z = (alu_res == 0), for all defined opcodes.
REQ-020 When s_bit=0, status is unchanged regardless of opcode.
REQ-021 Undefined opcodes (0, 11-15; 10 when MUL disabled): alu_res=0, out_valid=1 after 1 cycle, status unchanged.
REQ-022 out_valid clears on consumption unless a new result loads at the same edge, in which case out_valid stays 1 with the new alu_res.
REQ-023 While out_valid && !out_ready, alu_res and out_valid remain stable.
REQ-024 MUL: iterative shift-add, one multiplier bit per cycle, operands latched at acceptance; result = low WIDTH bits of val1*val2.
REQ-025 MUL result loads WIDTH cycles after acceptance (out_valid visible WIDTH+1 cycles after the accept edge) if the output slot is free; otherwise the FSM holds in MUL_BUSY with the product frozen until out_ready.

Reset
REQ-026 rst high at a clk edge: state=IDLE, out_valid=0, alu_res=0, status=4'b0000, multiply counter and operand registers cleared.
REQ-027 rst during MUL_BUSY aborts the multiply; no result is ever delivered for it.
REQ-028 in_ready is 0 while rst is high and 1 in the first cycle after release.

Configuration
REQ-029 Macro ALU_PIPE_MUL_EN: defined -> MUL (opcode 10) and state MUL_BUSY exist as specified.
REQ-030 ALU_PIPE_MUL_EN undefined -> no multiplier logic or MUL_BUSY state; opcode 10 is treated as undefined per REQ-021.

Verification (WIDTH=32)
REQ-031 Reset, ADD s_bit=1, 0x7FFFFFFF+0x00000001 -> next cycle out_valid=1, alu_res=0x80000000, status=4'b1001.
REQ-032 SUB s_bit=1, 3-5 -> 0xFFFFFFFE, status=4'b1000; then SBC s_bit=1, 10-3 -> 0x00000006, C=1.
REQ-033 ADD s_bit=0, 0xFFFFFFFF+0x00000001 -> alu_res=0, status unchanged from prior value.
REQ-034 out_ready=0 for 5 cycles after a result -> alu_res/out_valid stable, in_ready=0; out_ready=1 with in_valid=1 -> new result loads same edge, out_valid stays 1.
REQ-035 With ALU_PIPE_MUL_EN, MUL s_bit=1, 0x00010000*0x00010001 -> out_valid 33 cycles after accept, alu_res=0x00010000, N=0, Z=0, C/V unchanged; without macro -> alu_res=0 after 1 cycle, status unchanged.
REQ-036 rst pulsed 10 cycles into a MUL -> out_valid=0, status=0, in_ready=1 in the cycle after rst falls, no stale product ever appears.
